// File: rtl/road_speed_ctrl.sv
// Frame-rate speed controller for the road renderer: turns accel/brake keys and
// crash events into a 0..2 speed level, stepped once per frame, and accumulates distance.
module road_speed_ctrl #(
    parameter int unsigned ACCEL_FRAMES = 30,
    parameter int unsigned DECEL_FRAMES = 20,
    parameter int unsigned BRAKE_FRAMES = 6,
    parameter int unsigned CRASH_FRAMES = 90
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        gameEnable,
    input  logic        accelKey,
    input  logic        brakeKey,
    input  logic        crash,
    output logic [1:0]  speed,
    output logic        crashActive,
    output logic [15:0] distance
);

    typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_CRASH} state_t;
    typedef enum logic [1:0] {MODE_COAST, MODE_ACCEL, MODE_BRAKE} mode_t;

    localparam logic [7:0] ACCEL_THR = 8'(ACCEL_FRAMES);
    localparam logic [7:0] DECEL_THR = 8'(DECEL_FRAMES);
    localparam logic [7:0] BRAKE_THR = 8'(BRAKE_FRAMES);
    localparam logic [7:0] CRASH_THR = 8'(CRASH_FRAMES);

    state_t      state, state_n;
    mode_t       last_mode, last_mode_n, frame_mode;
    logic [7:0]  frame_cnt, frame_cnt_n, cnt_inc, thr;
    logic [1:0]  speed_n;
    logic        crash_active_n;
    logic [15:0] distance_n;
    logic [16:0] dist_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            last_mode   <= MODE_COAST;
            frame_cnt   <= 8'd0;
            speed       <= 2'd0;
            crashActive <= 1'b0;
            distance    <= 16'd0;
        end else begin
            state       <= state_n;
            last_mode   <= last_mode_n;
            frame_cnt   <= frame_cnt_n;
            speed       <= speed_n;
            crashActive <= crash_active_n;
            distance    <= distance_n;
        end
    end

    always_comb begin
        state_n        = state;
        last_mode_n    = last_mode;
        frame_cnt_n    = frame_cnt;
        speed_n        = speed;
        crash_active_n = crashActive;
        distance_n     = distance;

        if (brakeKey)      frame_mode = MODE_BRAKE;
        else if (accelKey) frame_mode = MODE_ACCEL;
        else               frame_mode = MODE_COAST;

        case (frame_mode)
            MODE_ACCEL: thr = ACCEL_THR;
            MODE_BRAKE: thr = BRAKE_THR;
            default:    thr = DECEL_THR;
        endcase

        cnt_inc  = frame_cnt + 8'd1;
        dist_sum = {1'b0, distance} + {15'd0, speed};

        if (!gameEnable) begin
            state_n        = ST_IDLE;
            speed_n        = 2'd0;
            crash_active_n = 1'b0;
            frame_cnt_n    = 8'd0;
            last_mode_n    = MODE_COAST;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n        = ST_DRIVE;
                    distance_n     = 16'd0;
                    speed_n        = 2'd0;
                    crash_active_n = 1'b0;
                    frame_cnt_n    = 8'd0;
                    last_mode_n    = MODE_COAST;
                end
                ST_DRIVE: begin
                    if (crash) begin
                        state_n        = ST_CRASH;
                        speed_n        = 2'd0;
                        crash_active_n = 1'b1;
                        frame_cnt_n    = 8'd0;
                    end else if (startOfFrame) begin
                        distance_n = dist_sum[16] ? 16'hFFFF : dist_sum[15:0];
                        // The frame that switches mode only arms the counter; it is not counted.
                        if (frame_mode != last_mode) begin
                            last_mode_n = frame_mode;
                            frame_cnt_n = 8'd0;
                        end else if (cnt_inc >= thr) begin
                            frame_cnt_n = 8'd0;
                            if (frame_mode == MODE_ACCEL) begin
                                if (speed < 2'd2) speed_n = speed + 2'd1;
                            end else begin
                                if (speed != 2'd0) speed_n = speed - 2'd1;
                            end
                        end else begin
                            frame_cnt_n = cnt_inc;
                        end
                    end
                end
                ST_CRASH: begin
                    // Further crash pulses are ignored here so the stall is never extended.
                    if (startOfFrame) begin
                        if (cnt_inc >= CRASH_THR) begin
                            state_n        = ST_DRIVE;
                            speed_n        = 2'd0;
                            crash_active_n = 1'b0;
                            frame_cnt_n    = 8'd0;
                            last_mode_n    = MODE_COAST;
                        end else begin
                            frame_cnt_n = cnt_inc;
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_road_speed_ctrl.sv
// Randomised and directed bench for road_speed_ctrl against a frame-level reference model.
module tb_road_speed_ctrl;

    localparam int ACCEL_N = 4;
    localparam int DECEL_N = 3;
    localparam int BRAKE_N = 2;
    localparam int CRASH_N = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        startOfFrame, gameEnable, accelKey, brakeKey, crash;
    logic [1:0]  speed;
    logic        crashActive;
    logic [15:0] distance;

    int n_checks = 0;
    int n_pass   = 0;
    logic cur_ge;

    // reference model: game phase 0=idle 1=driving 2=stalled; key mode 0=coast 1=accel 2=brake
    int m_phase, m_speed, m_crash, m_dist, m_mode, m_frames;

    road_speed_ctrl #(
        .ACCEL_FRAMES(ACCEL_N), .DECEL_FRAMES(DECEL_N),
        .BRAKE_FRAMES(BRAKE_N), .CRASH_FRAMES(CRASH_N)
    ) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .gameEnable(gameEnable),
        .accelKey(accelKey), .brakeKey(brakeKey), .crash(crash),
        .speed(speed), .crashActive(crashActive), .distance(distance)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_phase = 0; m_speed = 0; m_crash = 0; m_dist = 0; m_mode = 0; m_frames = 0;
    endtask

    task automatic model_step(input logic ge, sof, acc, brk, crs);
        int mode;
        int limit;
        if (!ge) begin
            m_phase = 0; m_speed = 0; m_crash = 0; m_mode = 0; m_frames = 0;
        end else if (m_phase == 0) begin
            m_phase = 1; m_dist = 0; m_speed = 0; m_mode = 0; m_frames = 0;
        end else if (m_phase == 1) begin
            if (crs) begin
                m_phase = 2; m_speed = 0; m_crash = 1; m_frames = 0;
            end else if (sof) begin
                mode = brk ? 2 : (acc ? 1 : 0);
                m_dist = (m_dist + m_speed > 65535) ? 65535 : m_dist + m_speed;
                if (mode != m_mode) begin
                    m_mode = mode;
                    m_frames = 0;
                end else begin
                    limit = (mode == 1) ? ACCEL_N : ((mode == 2) ? BRAKE_N : DECEL_N);
                    m_frames++;
                    if (m_frames >= limit) begin
                        m_frames = 0;
                        if (mode == 1) m_speed = (m_speed < 2) ? m_speed + 1 : 2;
                        else           m_speed = (m_speed > 0) ? m_speed - 1 : 0;
                    end
                end
            end
        end else if (sof) begin
            m_frames++;
            if (m_frames >= CRASH_N) begin
                m_phase = 1; m_speed = 0; m_crash = 0; m_frames = 0; m_mode = 0;
            end
        end
    endtask

    // Called at a falling edge; returns at the next falling edge with outputs settled.
    task automatic tick(input logic sof, acc, brk, crs);
        gameEnable = cur_ge; startOfFrame = sof; accelKey = acc; brakeKey = brk; crash = crs;
        model_step(cur_ge, sof, acc, brk, crs);
        @(negedge clk);
        startOfFrame = 1'b0; crash = 1'b0;
    endtask

    task automatic frame(input logic acc, brk, crs);
        repeat ($urandom_range(0, 2)) tick(1'b0, acc, brk, 1'b0);
        tick(1'b1, acc, brk, crs);
    endtask

    task automatic test_reset();
        n_checks++; if (speed !== 2'd0) $display("FAIL reset_speed: got %0d expected 0", speed); else n_pass++;
        n_checks++; if (crashActive !== 1'b0) $display("FAIL reset_crash: got %0b expected 0", crashActive); else n_pass++;
        n_checks++; if (distance !== 16'd0) $display("FAIL reset_distance: got %0d expected 0", distance); else n_pass++;
        reset = 1'b0;
        cur_ge = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (distance !== 16'd0 || speed !== 2'd0) $display("FAIL enter_drive: got spd %0d dist %0d expected 0/0", speed, distance); else n_pass++;
    endtask

    task automatic test_accel();
        int exp_spd;
        for (int k = 1; k <= 12; k++) begin
            frame(1'b1, 1'b0, 1'b0);
            exp_spd = (k < 5) ? 0 : ((k < 9) ? 1 : 2);
            n_checks++; if (speed !== 2'(exp_spd)) $display("FAIL accel_frame%0d: got %0d expected %0d", k, speed, exp_spd); else n_pass++;
        end
        n_checks++; if (distance !== 16'd10) $display("FAIL accel_distance: got %0d expected 10", distance); else n_pass++;
    endtask

    task automatic test_decel_brake();
        logic [1:0] coast_exp [4] = '{2'd2, 2'd2, 2'd2, 2'd1};
        logic [1:0] brake_exp [3] = '{2'd1, 2'd1, 2'd0};
        for (int k = 0; k < 4; k++) begin
            frame(1'b0, 1'b0, 1'b0);
            n_checks++; if (speed !== coast_exp[k]) $display("FAIL coast_frame%0d: got %0d expected %0d", k + 1, speed, coast_exp[k]); else n_pass++;
        end
        for (int k = 0; k < 3; k++) begin
            frame(1'b1, 1'b1, 1'b0);
            n_checks++; if (speed !== brake_exp[k]) $display("FAIL brake_frame%0d: got %0d expected %0d", k + 1, speed, brake_exp[k]); else n_pass++;
        end
    endtask

    task automatic test_crash();
        int d0;
        repeat (9) frame(1'b1, 1'b0, 1'b0);
        n_checks++; if (speed !== 2'd2) $display("FAIL crash_prep_speed: got %0d expected 2", speed); else n_pass++;
        d0 = m_dist;
        frame(1'b1, 1'b0, 1'b1);
        n_checks++; if (speed !== 2'd0 || crashActive !== 1'b1) $display("FAIL crash_entry: got spd %0d act %0b expected 0/1", speed, crashActive); else n_pass++;
        n_checks++; if (distance !== 16'(d0)) $display("FAIL crash_distance: got %0d expected %0d", distance, d0); else n_pass++;
        for (int k = 1; k <= CRASH_N; k++) begin
            if (k == 2) tick(1'b0, 1'b1, 1'b0, 1'b1);
            frame(1'b1, 1'b0, 1'b0);
            n_checks++; if (crashActive !== (k < CRASH_N)) $display("FAIL crash_stall%0d: got %0b expected %0b", k, crashActive, k < CRASH_N); else n_pass++;
        end
        n_checks++; if (speed !== 2'd0 || distance !== 16'(d0)) $display("FAIL crash_exit: got spd %0d dist %0d expected 0/%0d", speed, distance, d0); else n_pass++;
    endtask

    task automatic test_disable_in_crash();
        int d1;
        repeat (6) frame(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (crashActive !== 1'b1) $display("FAIL dis_crash_entry: got %0b expected 1", crashActive); else n_pass++;
        frame(1'b0, 1'b0, 1'b0);
        d1 = m_dist;
        cur_ge = 1'b0;
        repeat (3) tick(1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++; if (crashActive !== 1'b0 || speed !== 2'd0) $display("FAIL dis_idle: got act %0b spd %0d expected 0/0", crashActive, speed); else n_pass++;
        n_checks++; if (distance !== 16'(d1) || d1 == 0) $display("FAIL dis_hold: got %0d expected nonzero %0d", distance, d1); else n_pass++;
        cur_ge = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (distance !== 16'd0 || crashActive !== 1'b0) $display("FAIL dis_reenable: got dist %0d act %0b expected 0/0", distance, crashActive); else n_pass++;
    endtask

    task automatic test_random();
        logic acc, brk, sof, crs;
        int errs;
        acc = 1'b0; brk = 1'b0; errs = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                acc = 1'($urandom_range(0, 1));
                brk = ($urandom_range(0, 3) == 0);
            end
            sof = ($urandom_range(0, 1) == 0);
            crs = ($urandom_range(0, 59) == 0);
            cur_ge = ($urandom_range(0, 249) != 0);
            tick(sof, acc, brk, crs);
            n_checks++;
            if (speed !== 2'(m_speed) || crashActive !== 1'(m_crash) || distance !== 16'(m_dist)) begin
                if (errs < 10) $display("FAIL random_cyc%0d: got spd %0d act %0b dist %0d expected %0d/%0d/%0d",
                                        i, speed, crashActive, distance, m_speed, m_crash, m_dist);
                errs++;
            end else n_pass++;
        end
        cur_ge = 1'b1;
    endtask

    task automatic test_saturation();
        cur_ge = 1'b0; tick(1'b0, 1'b0, 1'b0, 1'b0);
        cur_ge = 1'b1; tick(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (32800) tick(1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++; if (distance !== 16'hFFFF || speed !== 2'd2) $display("FAIL sat_reach: got dist %0h spd %0d expected ffff/2", distance, speed); else n_pass++;
        frame(1'b1, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 1'b0);
        n_checks++; if (distance !== 16'hFFFF) $display("FAIL sat_hold: got %0h expected ffff", distance); else n_pass++;
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++; if (speed !== 2'd0 || crashActive !== 1'b0 || distance !== 16'd0)
            $display("FAIL async_reset: got spd %0d act %0b dist %0d expected 0/0/0", speed, crashActive, distance); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (3) frame(1'b1, 1'b0, 1'b0);
        n_checks++; if (speed !== 2'd0 || distance !== 16'd0) $display("FAIL post_reset: got spd %0d dist %0d expected 0/0", speed, distance); else n_pass++;
    endtask

    initial begin
        reset = 1'b1; cur_ge = 1'b0;
        startOfFrame = 1'b0; gameEnable = 1'b0; accelKey = 1'b0; brakeKey = 1'b0; crash = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_accel();
        test_decel_brake();
        test_crash();
        test_disable_in_crash();
        test_random();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
